ram_rr_arbiter: RTL
===================

// Module: ram_rr_arbiter
// PURPOSE
//  Stateful round-robin arbiter sharing the single RAM port among NREQ cache requesters
//  (index 0 = dcache0, 1 = dcache1, 2 = icache0, 3 = icache1 at top level).
//  Holds the grant across the whole RAM transaction and rotates priority after each completion.
//  Bounds RAM latency with a watchdog, so no requester hangs on a stuck RAM.
//  Sits between the cache_control_if requester side and the RAM model.
// PARAMETERS
//  NREQ     4    number of requesters; legal range 2..8
//  TIMEOUT  64   max cycles in GRANT without ACCESS before a forced release; legal range 2..255
// PORTS
//  CLK        in   1          clock, rising edge
//  nRST       in   1          synchronous active-low reset
//  req_ren    in   NREQ       per-requester read request
//  req_wen    in   NREQ       per-requester write request; WEN wins over REN inside one requester
//  req_addr   in   NREQx32    per-requester word address (word_t)
//  req_store  in   NREQx32    per-requester write data (word_t)
//  req_wait   out  NREQ       1 = stall; 0 for exactly one cycle = transaction done
//  req_err    out  NREQ       1 for one cycle, together with req_wait=0, on timeout or RAM ERROR
//  ramREN     out  1          RAM read enable
//  ramWEN     out  1          RAM write enable
//  ramaddr    out  32         RAM address
//  ramstore   out  32         RAM write data
//  ramstate   in   ramstate_t FREE/BUSY/ACCESS/ERROR (cpu_types_pkg)
//  gnt_idx    out  $clog2(NREQ) currently or last granted requester (debug/coherence visibility)
// BEHAVIOUR
//  Reset (nRST=0 at a rising edge):
//   - state=IDLE, last=NREQ-1, wdog=0, gnt_idx=0.
//   - req_wait all 1, req_err all 0, ramREN/ramWEN/ramaddr/ramstore all 0.
//   - Reset mid-transaction drops the grant; the RAM sees REN/WEN=0 from the next cycle.
//  Requests: req(i) = req_ren[i] | req_wen[i].
//  FSM IDLE:
//   - Outputs idle; no RAM enable asserted.
//   - If any req(i): pick the first i in rotating order last+1, last+2, ... (mod NREQ).
//   - Register it as gnt; clear wdog; go to GRANT.
//   - Grant is visible one cycle after the request is first seen (1-cycle arbitration latency).
//  FSM GRANT (outputs combinational from the registered gnt):
//   - ramWEN = req_wen[gnt]; ramREN = req_ren[gnt] & ~req_wen[gnt].
//   - ramaddr = req_addr[gnt]; ramstore = req_store[gnt] when writing, else 0.
//   - req_wait[gnt] = 0 in the cycle ramstate==ACCESS; all other req_wait stay 1.
//   - ACCESS: last<=gnt, go to IDLE.
//   - ERROR: req_wait[gnt]=0, req_err[gnt]=1, last<=gnt, go to IDLE.
//   - wdog==TIMEOUT-1 with no ACCESS/ERROR: req_wait[gnt]=0, req_err[gnt]=1, last<=gnt, go to IDLE.
//   - req(gnt) dropped before completion: abort to IDLE, last unchanged, no wait/err pulse.
//   - Otherwise wdog increments (saturating 8-bit).
//  Each completion costs one IDLE turnaround cycle; the RAM is never driven by two requesters.
//  Simultaneous requests: exactly one is granted; the others keep req_wait=1.
//  Fairness: a continuously requesting requester waits at most NREQ-1 completions.
//  Address and data are not latched; requesters must hold them stable while req_wait=1.
//  gnt_idx = gnt in GRANT, last in IDLE.
// TESTING
//  1 Reset, then req_ren=4'b1111 held -> grants in order 0,1,2,3,0; each req_wait low 1 cycle on ACCESS.
//  2 req_wen[1]=1, req_ren[1]=1, addr=0x40, data=0xDEADBEEF, ACCESS after 3 cycles
//    -> ramWEN=1, ramREN=0, ramaddr=0x40, ramstore=0xDEADBEEF; req_wait[1]=0 on cycle 4 only.
//  3 Req 2 granted, RAM held BUSY, TIMEOUT=8 -> req_wait[2]=0 and req_err[2]=1 at the 8th GRANT cycle;
//    next grant goes to 3.
//  4 Req 0 granted, req_ren[0] dropped before ACCESS -> IDLE next cycle, no pulse; pending req 0
//    re-requesting wins again (last unchanged).
//  5 nRST low during GRANT with WEN active -> next cycle ramWEN=0, all req_wait=1, first grant after
//    release goes to 0.
//  6 ramstate=ERROR during req 3 grant -> req_err[3]=1 and req_wait[3]=0 for one cycle; arbitration
//    resumes at 0.

Source files
------------

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// The grant is held for a whole RAM transaction; a watchdog forces release on a stuck RAM.
module ram_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      req_ren,
  input  logic [NREQ-1:0]      req_wen,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_store,
  output logic [NREQ-1:0]      req_wait,
  output logic [NREQ-1:0]      req_err,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [1:0]           ramstate,
  output logic [IW-1:0]        gnt_idx
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   gnt, gnt_n;
  logic [IW-1:0]   last, last_n;
  logic [IW-1:0]   gidx_n;
  logic [7:0]      wdog, wdog_n;

  logic [NREQ-1:0] req;
  logic [IW-1:0]   pick;
  logic            pick_found;
  logic            sel_ren, sel_wen;
  logic [31:0]     sel_addr, sel_store;

  assign req = req_ren | req_wen;

  // First requester in rotating order starting just after the last completed one.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last) + k) % NREQ);
      if (!pick_found && req[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ren   = 1'b0;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_store = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IW'(i)) begin
        sel_ren   = req_ren[i];
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[i*32 +: 32];
        sel_store = req_store[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      gnt     <= '0;
      last    <= IW'(NREQ - 1);
      wdog    <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      last    <= last_n;
      wdog    <= wdog_n;
      gnt_idx <= gidx_n;
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_n   = last;
    wdog_n   = wdog;
    gidx_n   = gnt_idx;
    req_wait = '1;
    req_err  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gnt_n   = pick;
          gidx_n  = pick;
          wdog_n  = '0;
        end
      end
      GRANT: begin
        ramWEN   = sel_wen;
        ramREN   = sel_ren & ~sel_wen;
        ramaddr  = sel_addr;
        ramstore = sel_wen ? sel_store : 32'h0;
        // A dropped request abandons the transaction silently; priority is not rotated.
        if (!(sel_ren | sel_wen)) begin
          state_n = IDLE;
          gidx_n  = last;
        end else if (ramstate == RAM_ACCESS) begin
          req_wait[gnt] = 1'b0;
          last_n        = gnt;
          state_n       = IDLE;
        end else if (ramstate == RAM_ERROR || wdog == 8'(TIMEOUT - 1)) begin
          req_wait[gnt] = 1'b0;
          req_err[gnt]  = 1'b1;
          last_n        = gnt;
          state_n       = IDLE;
        end else if (wdog != 8'hFF) begin
          wdog_n = wdog + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
